mutative_tag_ctrl: RTL and testbench

Initiator-side controller for the 128x20 single-port RW tag SRAM (active-low csb0/web0, inputs sampled on posedge, write at negedge, read data valid before the next posedge).
- After reset, or on flush, sweeps every entry to INIT_VALUE.
- In run mode, converts a valid/ready request stream from cache logic into SRAM port cycles.
- Returns read data with fixed 2-edge latency.

---
 rtl/mutative_tag_ctrl.sv | 129 ++++++++++++
 tb/tb_mutative_tag_ctrl.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/mutative_tag_ctrl.sv
// Initiator-side controller for a single-port RW tag SRAM: sweeps every entry to
// INIT_VALUE after reset or flush, then turns a valid/ready request stream into SRAM cycles.
module mutative_tag_ctrl #(
   parameter int                    DATA_WIDTH = 20,
   parameter int                    ADDR_WIDTH = 7,
   parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  flush,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_write,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  logic [DATA_WIDTH-1:0] req_wdata,
   output logic                  rsp_valid,
   output logic [DATA_WIDTH-1:0] rsp_rdata,
   output logic                  init_done,
   output logic                  sram_csb0,
   output logic                  sram_web0,
   output logic [ADDR_WIDTH-1:0] sram_addr0,
   output logic [DATA_WIDTH-1:0] sram_din0,
   input  logic [DATA_WIDTH-1:0] sram_dout0
);

   localparam int                    RAM_DEPTH = 1 << ADDR_WIDTH;
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(RAM_DEPTH - 1);

   typedef enum logic {
      ST_INIT,
      ST_RUN
   } state_e;

   state_e                  state_q, state_d;
   logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
   logic                    pend_q, pend_d;
   logic                    rsp_valid_q;
   logic [DATA_WIDTH-1:0]   rsp_rdata_q;
   logic                    accept;

   // flush takes priority over a concurrent request, which must be re-presented later
   assign accept = (state_q == ST_RUN) && req_valid && !flush;
   assign pend_d = accept && !req_write;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_INIT;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      case (state_q)
         ST_INIT: begin
            cnt_d = cnt_q + ADDR_WIDTH'(1);
            if (cnt_q == LAST_ADDR) begin
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            if (flush) begin
               state_d = ST_INIT;
               cnt_d   = '0;
            end
         end
         default: begin
            state_d = ST_INIT;
            cnt_d   = '0;
         end
      endcase
   end

   // The SRAM port is held idle for as long as reset is asserted, independent of state
   always_comb begin
      sram_csb0  = 1'b1;
      sram_web0  = 1'b1;
      sram_addr0 = '0;
      sram_din0  = '0;
      req_ready  = 1'b0;
      init_done  = 1'b0;
      if (rst_n) begin
         case (state_q)
            ST_INIT: begin
               sram_csb0  = 1'b0;
               sram_web0  = 1'b0;
               sram_addr0 = cnt_q;
               sram_din0  = INIT_VALUE;
            end
            ST_RUN: begin
               init_done = 1'b1;
               req_ready = !flush;
               if (accept) begin
                  sram_csb0  = 1'b0;
                  sram_web0  = !req_write;
                  sram_addr0 = req_addr;
                  sram_din0  = req_wdata;
               end
            end
            default: begin
               sram_csb0 = 1'b1;
            end
         endcase
      end
   end

   // Read data is valid one edge after the SRAM sampled the read, so capture it then
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pend_q      <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_rdata_q <= '0;
      end else begin
         pend_q      <= pend_d;
         rsp_valid_q <= pend_q;
         if (pend_q) begin
            rsp_rdata_q <= sram_dout0;
         end
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_rdata = rsp_rdata_q;

endmodule

// File: tb/tb_mutative_tag_ctrl.sv
// Self-checking bench for mutative_tag_ctrl: directed scenarios plus randomized
// traffic, compared cycle by cycle against a behavioural memory/response model.
module tb_mutative_tag_ctrl;

   localparam int DW    = 20;
   localparam int AW    = 7;
   localparam int DEPTH = 1 << AW;
   localparam logic [DW-1:0] INITV = '0;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          flush = 1'b0;
   logic          req_valid = 1'b0;
   logic          req_write = 1'b0;
   logic [AW-1:0] req_addr = '0;
   logic [DW-1:0] req_wdata = '0;
   logic          req_ready;
   logic          rsp_valid;
   logic [DW-1:0] rsp_rdata;
   logic          init_done;
   logic          sram_csb0;
   logic          sram_web0;
   logic [AW-1:0] sram_addr0;
   logic [DW-1:0] sram_din0;
   logic [DW-1:0] sram_dout0;

   int checkCount = 0;
   int errorCount = 0;

   mutative_tag_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .INIT_VALUE(INITV)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush      (flush),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_write  (req_write),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .rsp_valid  (rsp_valid),
      .rsp_rdata  (rsp_rdata),
      .init_done  (init_done),
      .sram_csb0  (sram_csb0),
      .sram_web0  (sram_web0),
      .sram_addr0 (sram_addr0),
      .sram_din0  (sram_din0),
      .sram_dout0 (sram_dout0)
   );

   always #5 clk = ~clk;

   // Behavioural SRAM: port sampled on posedge, write or read performed at the following negedge
   logic [DW-1:0] sramMem [DEPTH];
   logic          latCsb = 1'b1;
   logic          latWeb = 1'b1;
   logic [AW-1:0] latAddr = '0;
   logic [DW-1:0] latDin = '0;
   logic [DW-1:0] sramDout = '0;
   assign sram_dout0 = sramDout;

   always @(posedge clk) begin
      latCsb  <= sram_csb0;
      latWeb  <= sram_web0;
      latAddr <= sram_addr0;
      latDin  <= sram_din0;
   end

   always @(negedge clk) begin
      if (!latCsb) begin
         if (!latWeb) sramMem[latAddr] = latDin;
         else         sramDout = sramMem[latAddr];
      end
   end

   // Reference model: contents of the tag store, sweep progress and scheduled responses
   typedef struct {
      int          due;
      logic [DW-1:0] data;
   } rsp_t;

   logic [DW-1:0] refMem [DEPTH];
   bit            mRun = 1'b0;
   int            mSweep = 0;
   int            edgeNum = 0;
   rsp_t          rspQ[$];
   bit            expValid = 1'b0;
   logic [DW-1:0] expData = '0;

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checkCount++;
      if (observed !== expected) begin
         errorCount++;
         $display("[TB] FAIL %s: observed 0x%0h expected 0x%0h (t=%0t)", tag, observed, expected, $time);
      end
   endtask

   // Drives one cycle of inputs, checks everything visible in that cycle, then advances one edge
   task automatic applyStimulus(input bit v, input bit w, input int a, input int d, input bit f);
      bit   eCsb, eWeb, eReady, eDone, acc;
      int   eAddr, eDin;
      req_valid = v;
      req_write = w;
      req_addr  = AW'(a);
      req_wdata = DW'(d);
      flush     = f;
      #1;
      if (!mRun) begin
         acc = 1'b0; eReady = 1'b0; eDone = 1'b0;
         eCsb = 1'b0; eWeb = 1'b0; eAddr = mSweep; eDin = int'(INITV);
      end else begin
         acc    = v && !f;
         eReady = !f;
         eDone  = 1'b1;
         eCsb   = !acc;
         eWeb   = acc ? !w : 1'b1;
         eAddr  = acc ? (a % DEPTH) : 0;
         eDin   = acc ? (d % (1 << DW)) : 0;
      end
      checkOutput("req_ready",  32'(req_ready),  32'(eReady));
      checkOutput("init_done",  32'(init_done),  32'(eDone));
      checkOutput("sram_csb0",  32'(sram_csb0),  32'(eCsb));
      checkOutput("sram_web0",  32'(sram_web0),  32'(eWeb));
      checkOutput("sram_addr0", 32'(sram_addr0), eAddr);
      checkOutput("sram_din0",  32'(sram_din0),  eDin);
      checkOutput("rsp_valid",  32'(rsp_valid),  32'(expValid));
      checkOutput("rsp_rdata",  32'(rsp_rdata),  32'(expData));
      @(posedge clk);
      edgeNum++;
      if (!mRun) begin
         refMem[mSweep] = INITV;
         mSweep++;
         if (mSweep == DEPTH) begin
            mRun   = 1'b1;
            mSweep = 0;
         end
      end else if (f) begin
         mRun   = 1'b0;
         mSweep = 0;
      end else if (acc) begin
         if (w) refMem[a % DEPTH] = DW'(d);
         else   rspQ.push_back('{due: edgeNum + 1, data: refMem[a % DEPTH]});
      end
      expValid = 1'b0;
      if (rspQ.size() > 0 && rspQ[0].due == edgeNum) begin
         expValid = 1'b1;
         expData  = rspQ[0].data;
         void'(rspQ.pop_front());
      end
      #1;
   endtask

   // Asserts reset between edges, checks the idle port immediately, holds two edges, releases
   task automatic doReset();
      rst_n     = 1'b0;
      req_valid = 1'b0;
      flush     = 1'b0;
      #1;
      checkOutput("rst_csb0",  32'(sram_csb0),  32'd1);
      checkOutput("rst_web0",  32'(sram_web0),  32'd1);
      checkOutput("rst_addr0", 32'(sram_addr0), 32'd0);
      checkOutput("rst_din0",  32'(sram_din0),  32'd0);
      checkOutput("rst_rspv",  32'(rsp_valid),  32'd0);
      checkOutput("rst_rdata", 32'(rsp_rdata),  32'd0);
      checkOutput("rst_done",  32'(init_done),  32'd0);
      checkOutput("rst_ready", 32'(req_ready),  32'd0);
      mRun     = 1'b0;
      mSweep   = 0;
      rspQ.delete();
      expValid = 1'b0;
      expData  = '0;
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic idleCycles(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 0, 0, 1'b0);
   endtask

   // Sweep cycles with junk requests and flushes that must all be ignored
   task automatic sweepCycles(input int n);
      for (int i = 0; i < n; i++)
         applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                       int'($urandom_range(0, DEPTH - 1)), int'($urandom & 32'hFFFFF),
                       1'($urandom_range(0, 1)));
   endtask

   initial begin
      #3;
      doReset();
      sweepCycles(DEPTH);

      applyStimulus(1'b1, 1'b1, 5, 'hABCDE, 1'b0);
      applyStimulus(1'b1, 1'b0, 5, 0, 1'b0);
      idleCycles(2);
      checkOutput("raw_rdata_abcde", 32'(rsp_rdata), 32'h000ABCDE);

      applyStimulus(1'b1, 1'b1, 1, 'h11111, 1'b0);
      applyStimulus(1'b1, 1'b1, 2, 'h22222, 1'b0);
      applyStimulus(1'b1, 1'b1, 3, 'h33333, 1'b0);
      applyStimulus(1'b1, 1'b0, 1, 0, 1'b0);
      applyStimulus(1'b1, 1'b0, 2, 0, 1'b0);
      applyStimulus(1'b1, 1'b0, 3, 0, 1'b0);
      idleCycles(3);
      checkOutput("b2b_last_rdata", 32'(rsp_rdata), 32'h00033333);

      applyStimulus(1'b1, 1'b0, 5, 0, 1'b0);
      applyStimulus(1'b1, 1'b1, 5, 'h55555, 1'b1);
      sweepCycles(DEPTH);
      checkOutput("flush_rdata_kept", 32'(rsp_rdata), 32'h000ABCDE);
      applyStimulus(1'b1, 1'b0, 5, 0, 1'b0);
      idleCycles(2);
      checkOutput("post_flush_read5", 32'(rsp_rdata), 32'd0);

      doReset();
      sweepCycles(60);
      doReset();
      sweepCycles(DEPTH);

      applyStimulus(1'b1, 1'b1, 7, 'h77777, 1'b0);
      applyStimulus(1'b1, 1'b0, 7, 0, 1'b0);
      doReset();
      sweepCycles(DEPTH);
      idleCycles(2);

      for (int i = 0; i < 1500; i++) begin
         int a;
         a = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 7)) : int'($urandom_range(0, DEPTH - 1));
         applyStimulus(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)), a,
                       int'($urandom & 32'hFFFFF), 1'($urandom_range(0, 99) == 0));
      end
      idleCycles(3);

      $display("CHECKS %0d ERRORS %0d", checkCount, errorCount);
      $finish;
   end

endmodule
